// File: rtl/bnn_xnor_datapath.sv
// XNOR-popcount datapath for one binarized-conv output pixel.
// Define BNN_DP_FRAME_DONE_EN to add the frame_done pulse output.
module bnn_xnor_datapath #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int NWORDS  = 9,
  parameter int NUM_OUT = 4,
  parameter int THRESH  = 72,
  parameter int CNT_W   = $clog2(NWORDS*DATA_W+1),
  parameter int OUT_W   = CNT_W+1,
  parameter int OADDR_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         ctrl_in,
  output logic [3:0]         ctrl_out,
  output logic [ADDR_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [DATA_W-1:0]  w_data,
  output logic [OADDR_W-1:0] out_addr,
  output logic [OUT_W-1:0]   out_data
`ifdef BNN_DP_FRAME_DONE_EN
  ,
  output logic               frame_done
`endif
);

  localparam int KW = $clog2(NWORDS+1);
  localparam logic [KW-1:0] NW_K = KW'(NWORDS);
  localparam logic [KW-1:0] NW_K1 = KW'(NWORDS-1);
  localparam logic [ADDR_W-1:0] NW_A = ADDR_W'(NWORDS);
  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);
  localparam logic [OADDR_W-1:0] P_LAST = OADDR_W'(NUM_OUT-1);

  typedef enum logic [2:0] {
    IDLE, ADDR, FETCH, HOLD, ACT, WRITE
  } state_t;

  state_t state, nxt;

  logic get_address, get_data, count_ready, write_ready;
  logic [KW-1:0] k;
  logic rd_vld;
  logic last;
  logic [CNT_W-1:0] acc;
  logic sign;
  logic [OADDR_W-1:0] p;
  logic [ADDR_W-1:0] base;

  assign get_address = ctrl_in[3];
  assign get_data    = ctrl_in[2];
  assign count_ready = ctrl_in[1];
  assign write_ready = ctrl_in[0];
  assign out_addr    = p;

  // rd_vld marks the cycle whose in_data answers last cycle's address
  assign last = rd_vld && (k == NW_K);

  function automatic logic [CNT_W-1:0] pop_match(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] x;
    logic [CNT_W-1:0] n;
    x = ~(a ^ b);
    n = '0;
    for (int i = 0; i < DATA_W; i++)
      n = n + CNT_W'(x[i]);
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (get_address) nxt = ADDR;
      ADDR:  if (!get_address && get_data) nxt = FETCH;
      FETCH: if (last) nxt = HOLD;
      HOLD:  if (count_ready) nxt = ACT;
      ACT:   if (write_ready) nxt = WRITE;
      WRITE: if (!write_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_out <= '0;
      in_addr  <= '0;
      out_data <= '0;
      k        <= '0;
      rd_vld   <= 1'b0;
      acc      <= '0;
      sign     <= 1'b0;
      p        <= '0;
      base     <= '0;
    end else begin
      ctrl_out[3] <= get_data & (nxt == HOLD || state == HOLD);
      ctrl_out[2] <= (nxt == ADDR);
      ctrl_out[1] <= count_ready & (nxt == ACT || state == ACT);
      ctrl_out[0] <= write_ready & (nxt == WRITE);

      if (state == IDLE && get_address) begin
        in_addr <= base;
        k       <= '0;
        acc     <= '0;
        rd_vld  <= 1'b0;
      end

      if (state == FETCH) begin
        if (k < NW_K) begin
          k      <= k + KW'(1);
          rd_vld <= 1'b1;
          if (k < NW_K1)
            in_addr <= base + ADDR_W'(k) + ADDR_W'(1);
        end else begin
          rd_vld <= 1'b0;
        end
        if (rd_vld)
          acc <= acc + pop_match(in_data, w_data);
      end

      if (state == HOLD && count_ready)
        sign <= (acc >= TH);

      if (state == ACT && write_ready)
        out_data <= {sign, acc};

      if (state == WRITE && !write_ready) begin
        if (p == P_LAST) begin
          p    <= '0;
          base <= '0;
        end else begin
          p    <= p + OADDR_W'(1);
          base <= base + NW_A;
        end
      end
    end
  end

`ifdef BNN_DP_FRAME_DONE_EN
  always_ff @(posedge clk) begin
    if (reset)
      frame_done <= 1'b0;
    else
      frame_done <= (state == WRITE) && !write_ready && (p == P_LAST);
  end
`endif

endmodule

// File: tb/tb_bnn_xnor_datapath.sv
// Directed bench for bnn_xnor_datapath.
// Plays the controller side of the handshake with hand-computed results.
module tb_bnn_xnor_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ctrl_in;
  logic [3:0]  ctrl_out;
  logic [7:0]  in_addr;
  logic [15:0] in_data;
  logic [15:0] w_data;
  logic [1:0]  out_addr;
  logic [8:0]  out_data;
`ifdef BNN_DP_FRAME_DONE_EN
  logic        frame_done;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bnn_xnor_datapath dut (
    .clk(clk),
    .reset(reset),
    .ctrl_in(ctrl_in),
    .ctrl_out(ctrl_out),
    .in_addr(in_addr),
    .in_data(in_data),
    .w_data(w_data),
    .out_addr(out_addr),
    .out_data(out_data)
`ifdef BNN_DP_FRAME_DONE_EN
    ,
    .frame_done(frame_done)
`endif
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full pixel; words outside the capture window carry junk
  task automatic run_pixel(
    input string       tag,
    input logic [15:0] din,
    input logic [15:0] wd,
    input bit          ramp,
    input logic [8:0]  exp_data,
    input logic [1:0]  exp_oaddr,
    input logic [7:0]  exp_base,
    input bit          exp_wrap
  );
    int c;
    logic [15:0] junk;
    logic [1:0] nx;
    junk = din ^ 16'h5A5A;
    nx = exp_oaddr + 2'd1;
    in_data = junk;
    w_data = wd;
    ctrl_in = 4'b1000;
    @(negedge clk);
    check({tag, " rts"}, 32'(ctrl_out), 'b0100);
    ctrl_in = 4'b0100;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ctrl_out[3]) break;
      if (c < 9)
        check({tag, " in_addr"}, 32'(in_addr), exp_base + c);
      if (c >= 1 && c <= 9)
        in_data = ramp ? (16'hFFFF >> (16 - c)) : din;
      else
        in_data = junk;
    end
    check({tag, " got_lat"}, c, 10);
    check({tag, " got"}, 32'(ctrl_out), 'b1000);
    ctrl_in = 4'b0010;
    @(negedge clk);
    check({tag, " cdone"}, 32'(ctrl_out), 'b0010);
    ctrl_in = 4'b0001;
    @(negedge clk);
    check({tag, " ws"}, 32'(ctrl_out), 'b0001);
    check({tag, " oaddr"}, 32'(out_addr), 32'(exp_oaddr));
    check({tag, " odata"}, 32'(out_data), 32'(exp_data));
    @(negedge clk);
    check({tag, " ws_hold"}, 32'(ctrl_out), 'b0001);
    check({tag, " odata_hold"}, 32'(out_data), 32'(exp_data));
    ctrl_in = 4'b0000;
    @(negedge clk);
    check({tag, " idle"}, 32'(ctrl_out), 'b0000);
    check({tag, " odata_idle"}, 32'(out_data), 32'(exp_data));
    check({tag, " next_p"}, 32'(out_addr), 32'(nx));
`ifdef BNN_DP_FRAME_DONE_EN
    check({tag, " fdone"}, 32'(frame_done), 32'(exp_wrap));
    @(negedge clk);
    check({tag, " fdone_off"}, 32'(frame_done), 'b0);
`else
    if (exp_wrap) @(negedge clk);
    else @(negedge clk);
`endif
  endtask

  initial begin
    reset = 1'b1;
    ctrl_in = 4'b0000;
    in_data = '0;
    w_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst ctrl_out", 32'(ctrl_out), 'b0);
      check("rst in_addr", 32'(in_addr), 'b0);
      check("rst out_data", 32'(out_data), 'b0);
      check("rst out_addr", 32'(out_addr), 'b0);
    end

    run_pixel("px0", 16'hFFFF, 16'hFFFF, 1'b0, 9'h190, 2'd0, 8'd0, 1'b0);
    run_pixel("px1", 16'h1234, 16'hEDCB, 1'b0, 9'h000, 2'd1, 8'd9, 1'b0);
    run_pixel("px2", 16'h00FF, 16'h0000, 1'b0, 9'h148, 2'd2, 8'd18, 1'b0);
    run_pixel("px3", 16'hFFFF, 16'hFFFF, 1'b1, 9'h02D, 2'd3, 8'd27, 1'b1);
    run_pixel("px4", 16'hFFFF, 16'hFFFF, 1'b0, 9'h190, 2'd0, 8'd0, 1'b0);

    // abort pixel 1 at k = 4; reset also coincides with a new request
    ctrl_in = 4'b1000;
    @(negedge clk);
    ctrl_in = 4'b0100;
    for (int c = 0; c < 5; c++) @(negedge clk);
    check("abort in_addr", 32'(in_addr), 13);
    reset = 1'b1;
    ctrl_in = 4'b1000;
    @(negedge clk);
    reset = 1'b0;
    ctrl_in = 4'b0000;
    check("abort ctrl_out", 32'(ctrl_out), 'b0);
    check("abort in_addr0", 32'(in_addr), 'b0);
    check("abort out_addr", 32'(out_addr), 'b0);
    check("abort out_data", 32'(out_data), 'b0);
    @(negedge clk);
    check("abort idle", 32'(ctrl_out), 'b0);

    run_pixel("rerun", 16'hFFFF, 16'hFFFF, 1'b0, 9'h190, 2'd0, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
